// File: rtl/axi_lite_master_if.sv
// Bundle of the CPU request/response port and the AXI-lite AW/W/B/AR/R channels
// seen by axi_lite_master. The master modport is the initiator view. The slave
// modport is the view of whatever sits on the far side: the CPU for req/rsp and
// the memory slave for the AXI channels.
//
// Handshake rule for every channel here: a transfer happens on a rising clk edge
// where valid and ready are both 1. Once a sender raises valid, it keeps valid and
// its payload stable until that transfer. Ready may be raised or lowered freely.
interface axi_lite_master_if #(
    parameter int addr_width = 32,
    parameter int data_width = 64
);
    // CPU request
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [addr_width-1:0]     req_addr;
    logic [data_width-1:0]     req_wdata;
    logic [data_width/8-1:0]   req_wmask;
    // CPU response
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [data_width-1:0]     rsp_rdata;
    logic                      rsp_err;
    // AXI-lite write address / data / response
    logic                      awvalid;
    logic                      awready;
    logic [addr_width-1:0]     awaddr;
    logic                      wvalid;
    logic                      wready;
    logic [data_width-1:0]     wdata;
    logic [data_width/8-1:0]   wmask;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    // AXI-lite read address / data
    logic [addr_width-1:0]     araddr;
    logic                      arvalid;
    logic                      arready;
    logic                      rvalid;
    logic                      rready;
    logic [data_width-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output awvalid, awaddr, wvalid, wdata, wmask, bready,
        input  awready, wready, bvalid, bresp,
        output araddr, arvalid, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wmask,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  awvalid, awaddr, wvalid, wdata, wmask, bready,
        output awready, wready, bvalid, bresp,
        input  araddr, arvalid, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_master.sv
// AXI-lite initiator: converts one CPU load/store at a time into an AR/R or
// AW/W/B transaction and returns the data (or write completion) plus an error flag.
// Every valid/ready output is decoded from the state register or from the
// aw_done/w_done flags, so no AXI input reaches a handshake output combinationally.
// state_dbg exposes the FSM encoding:
// IDLE=0, AR=1, R=2, WR=3, B=4, RSP=5.
module axi_lite_master #(
    parameter int addr_width = 32,
    parameter int data_width = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_lite_master_if.master    bus,
    output logic [2:0]           state_dbg
);
    localparam int strb_width = data_width / 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        WR   = 3'd3,
        B    = 3'd4,
        RSP  = 3'd5
    } state_t;

    state_t                  state, state_n;
    logic                    aw_done, aw_done_n;
    logic                    w_done, w_done_n;

    logic [addr_width-1:0]   araddr_q;
    logic [addr_width-1:0]   awaddr_q;
    logic [data_width-1:0]   wdata_q;
    logic [strb_width-1:0]   wmask_q;
    logic [data_width-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;

    logic                    req_fire;

    // Only the top bit of a response code separates OKAY/EXOKAY from SLVERR/DECERR.
    logic                    unused_resp_lsb;
    assign unused_resp_lsb = bus.rresp[0] ^ bus.bresp[0];

    // req_ready is also gated by rst_n, so it stays low while reset is held.
    assign req_fire = bus.req_valid && (state == IDLE);

    // State register plus the per-channel write completion flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
        end
    end

    // Next-state logic. AW and W complete independently. B is entered once both
    // are done, whether they finish together or one after the other.
    always_comb begin
        state_n   = state;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_we) begin
                        state_n   = WR;
                        aw_done_n = 1'b0;
                        w_done_n  = 1'b0;
                    end else begin
                        state_n = AR;
                    end
                end
            end
            AR: begin
                if (bus.arready) state_n = R;
            end
            R: begin
                if (bus.rvalid) state_n = RSP;
            end
            WR: begin
                if (bus.awready) aw_done_n = 1'b1;
                if (bus.wready)  w_done_n  = 1'b1;
                if (aw_done_n && w_done_n) state_n = B;
            end
            B: begin
                if (bus.bvalid) state_n = RSP;
            end
            RSP: begin
                if (bus.rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request latch and response capture. These registers change only in IDLE, R
    // and B, so AXI payloads stay stable while their valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            araddr_q    <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (req_fire) begin
                if (bus.req_we) begin
                    awaddr_q <= bus.req_addr;
                    wdata_q  <= bus.req_wdata;
                    wmask_q  <= bus.req_wmask;
                end else begin
                    araddr_q <= bus.req_addr;
                end
            end
            if (state == R && bus.rvalid) begin
                rsp_rdata_q <= bus.rdata;
                rsp_err_q   <= bus.rresp[1];
            end
            if (state == B && bus.bvalid) begin
                rsp_rdata_q <= '0;
                rsp_err_q   <= bus.bresp[1];
            end
        end
    end

    assign bus.req_ready = (state == IDLE) && rst_n;
    assign bus.arvalid   = (state == AR);
    assign bus.rready    = (state == R);
    assign bus.awvalid   = (state == WR) && !aw_done;
    assign bus.wvalid    = (state == WR) && !w_done;
    assign bus.bready    = (state == B);
    assign bus.rsp_valid = (state == RSP);

    assign bus.araddr    = araddr_q;
    assign bus.awaddr    = awaddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.wmask     = wmask_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    assign state_dbg     = state;
endmodule
